// File: rtl/queue_release_scheduler_pkg.sv
// Shared widths, FIFO geometry, watchdog limit and FSM encodings for the
// queue release scheduler.
package queue_release_scheduler_pkg;

    localparam int QID_W      = 5;
    localparam int FRAG_W     = 4;
    localparam int FIFO_DEPTH = 32;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = FIFO_AW + 1;
    localparam int WDOG_W     = 8;

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_REQ  = 2'd2,
        ST_FREE = 2'd3
    } state_t;

    typedef struct packed {
        logic [QID_W-1:0]  queue_id;
        logic [FRAG_W-1:0] frag_num;
    } entry_t;

endpackage

// File: rtl/queue_release_scheduler_if.sv
// Completion, fragment-read, free and status signals of the scheduler.
// The master side drives completions and acks; the slave side is the scheduler.
interface queue_release_scheduler_if;
    import queue_release_scheduler_pkg::*;

    logic [QID_W-1:0]  iv_queue_id;
    logic [FRAG_W-1:0] iv_frag_num;
    logic              i_queue_complete_wr;
    logic [QID_W-1:0]  ov_rd_queue_id;
    logic [FRAG_W-1:0] ov_rd_frag_id;
    logic              o_rd_req;
    logic              i_rd_ack;
    logic [QID_W-1:0]  ov_queue_id_free;
    logic              o_queue_id_free_wr;
    logic [CNT_W-1:0]  ov_pending_cnt;
    logic              o_overflow_pulse;
    logic              o_illegal_pulse;
    logic              o_timeout_pulse;

    modport master (
        output iv_queue_id, iv_frag_num, i_queue_complete_wr, i_rd_ack,
        input  ov_rd_queue_id, ov_rd_frag_id, o_rd_req, ov_queue_id_free,
               o_queue_id_free_wr, ov_pending_cnt, o_overflow_pulse,
               o_illegal_pulse, o_timeout_pulse
    );

    modport slave (
        input  iv_queue_id, iv_frag_num, i_queue_complete_wr, i_rd_ack,
        output ov_rd_queue_id, ov_rd_frag_id, o_rd_req, ov_queue_id_free,
               o_queue_id_free_wr, ov_pending_cnt, o_overflow_pulse,
               o_illegal_pulse, o_timeout_pulse
    );

endinterface

// File: rtl/queue_release_scheduler_fifo.sv
// 32x9 completion FIFO with a registered read port and an occupancy count.
// Writes when full and reads when empty are ignored.
module completion_fifo
    import queue_release_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  entry_t           wr_data,
    input  logic             rd_en,
    output entry_t           rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] usedw
);

    entry_t             mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_wr;
    logic               do_rd;

    assign full  = (usedw == CNT_W'(FIFO_DEPTH));
    assign empty = (usedw == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            usedw   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: usedw <= usedw;
            endcase
        end
    end

endmodule

// File: rtl/queue_release_scheduler.sv
// Buffers completed packets and drains them one queue at a time, fragment by
// fragment, returning each queue id once drained or abandoned by the watchdog.
module queue_release_scheduler
    import queue_release_scheduler_pkg::*;
(
    input logic                      i_clk,
    input logic                      i_rst_n,
    queue_release_scheduler_if.slave bus
);

    state_t            state;
    state_t            state_next;
    entry_t            wr_entry;
    entry_t            head;
    logic              strobe_legal;
    logic              fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_usedw;
    logic [QID_W-1:0]  cur_id;
    logic [FRAG_W-1:0] cur_num;
    logic [FRAG_W-1:0] frag_cnt;
    logic [QID_W-1:0]  free_id;
    logic [WDOG_W-1:0] wdog;
    logic              last_frag;
    logic              wdog_expire;
    logic              rd_req;
    logic              free_wr;
    logic              timeout_pulse;
    logic              overflow_q;
    logic              illegal_q;

    assign strobe_legal = bus.i_queue_complete_wr && (bus.iv_frag_num != '0);
    assign wr_entry     = '{queue_id: bus.iv_queue_id, frag_num: bus.iv_frag_num};
    assign last_frag    = (frag_cnt == cur_num - FRAG_W'(1));
    // Expiry fires in the unacknowledged request cycle that brings the count to the limit.
    assign wdog_expire  = !bus.i_rd_ack && (wdog == WDOG_LIMIT - WDOG_W'(1));

    completion_fifo u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (strobe_legal),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .usedw   (fifo_usedw)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!fifo_empty) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_REQ;
            ST_REQ:  if ((bus.i_rd_ack && last_frag) || wdog_expire) state_next = ST_FREE;
            ST_FREE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd       = 1'b0;
        rd_req        = 1'b0;
        free_wr       = 1'b0;
        timeout_pulse = 1'b0;
        case (state)
            ST_IDLE: fifo_rd = !fifo_empty;
            ST_REQ: begin
                rd_req        = 1'b1;
                timeout_pulse = wdog_expire;
            end
            ST_FREE: free_wr = 1'b1;
            default: ;
        endcase
    end

    // Drain context only changes on edges into REQ/FREE, so outputs hold elsewhere.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_id     <= '0;
            cur_num    <= '0;
            frag_cnt   <= '0;
            free_id    <= '0;
            wdog       <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            overflow_q <= strobe_legal && fifo_full;
            illegal_q  <= bus.i_queue_complete_wr && (bus.iv_frag_num == '0);
            if (state == ST_LOAD) begin
                cur_id   <= head.queue_id;
                cur_num  <= head.frag_num;
                frag_cnt <= '0;
                wdog     <= '0;
            end
            if (state == ST_REQ) begin
                if (bus.i_rd_ack) begin
                    wdog <= '0;
                    if (!last_frag) begin
                        frag_cnt <= frag_cnt + 1'b1;
                    end
                end else begin
                    wdog <= wdog + 1'b1;
                end
                if (state_next == ST_FREE) begin
                    free_id <= cur_id;
                end
            end
        end
    end

    assign bus.ov_rd_queue_id     = cur_id;
    assign bus.ov_rd_frag_id      = frag_cnt;
    assign bus.o_rd_req           = rd_req;
    assign bus.ov_queue_id_free   = free_id;
    assign bus.o_queue_id_free_wr = free_wr;
    assign bus.ov_pending_cnt     = fifo_usedw;
    assign bus.o_overflow_pulse   = overflow_q;
    assign bus.o_illegal_pulse    = illegal_q;
    assign bus.o_timeout_pulse    = timeout_pulse;

endmodule

// File: tb/tb_queue_release_scheduler.sv
// Directed bench for queue_release_scheduler: stimulus pushes expected
// fragment reads and frees into queues that a negedge monitor pops and compares.
module tb_queue_release_scheduler;

    typedef struct packed {
        logic [4:0] q;
        logic [3:0] f;
    } exp_req_t;

    logic clk = 1'b0;
    logic rst_n;

    queue_release_scheduler_if bus ();

    queue_release_scheduler dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_req_t   exp_req [$];
    logic [4:0] exp_free [$];
    exp_req_t   mon_e;
    logic [4:0] mon_id;

    int num_checks = 0;
    int num_pass = 0;
    int frees_seen = 0;
    int ovf_seen = 0;
    int ill_seen = 0;
    int timeout_seen = 0;
    int req_run = 0;
    int req_cycles = 0;
    bit free_next_due = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual === expected) begin
            num_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {7'd0, bus.o_rd_req, bus.ov_rd_queue_id, bus.ov_rd_frag_id, bus.ov_queue_id_free,
                bus.o_queue_id_free_wr, bus.ov_pending_cnt, bus.o_overflow_pulse,
                bus.o_illegal_pulse, bus.o_timeout_pulse};
    endfunction

    task automatic sync_to_drive();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge; the strobe is sampled at the next edge.
    task automatic apply_stimulus(input logic [4:0] q, input logic [3:0] n);
        bus.iv_queue_id         = q;
        bus.iv_frag_num         = n;
        bus.i_queue_complete_wr = 1'b1;
        @(posedge clk);
        #1;
        bus.i_queue_complete_wr = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!bus.o_rd_req && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output("wait_req", {31'd0, bus.o_rd_req}, 32'd1);
    endtask

    task automatic wait_frees(input int target, input int budget);
        int n = 0;
        while (frees_seen < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output("wait_frees", frees_seen, target);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_req.delete();
        exp_free.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            req_run       = 0;
            free_next_due = 1'b0;
        end else begin
            if (free_next_due) begin
                check_output("free_after_timeout", {31'd0, bus.o_queue_id_free_wr}, 32'd1);
                free_next_due = 1'b0;
            end
            if (bus.o_rd_req) begin
                req_cycles++;
            end
            if (bus.o_rd_req && bus.i_rd_ack) begin
                req_run = 0;
                if (exp_req.size() == 0) begin
                    check_output("req_unexpected", exp_req.size(), 1);
                end else begin
                    mon_e = exp_req.pop_front();
                    check_output("req_queue_id", bus.ov_rd_queue_id, mon_e.q);
                    check_output("req_frag_id", bus.ov_rd_frag_id, mon_e.f);
                end
            end else if (bus.o_rd_req) begin
                req_run++;
            end else begin
                req_run = 0;
            end
            if (bus.o_timeout_pulse) begin
                timeout_seen++;
                check_output("timeout_req_cycles", req_run, 255);
                req_run       = 0;
                free_next_due = 1'b1;
            end
            if (bus.o_queue_id_free_wr) begin
                frees_seen++;
                if (exp_free.size() == 0) begin
                    check_output("free_unexpected", exp_free.size(), 1);
                end else begin
                    mon_id = exp_free.pop_front();
                    check_output("free_queue_id", bus.ov_queue_id_free, mon_id);
                end
            end
            if (bus.o_overflow_pulse) ovf_seen++;
            if (bus.o_illegal_pulse) ill_seen++;
        end
    end

    initial begin
        int frees_base;
        rst_n                   = 1'b0;
        bus.iv_queue_id         = '0;
        bus.iv_frag_num         = '0;
        bus.i_queue_complete_wr = 1'b0;
        bus.i_rd_ack            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs", out_vec(), 32'd0);
        rst_n = 1'b1;

        // Single packet into an idle block: request two edges after the strobe is sampled.
        bus.i_rd_ack = 1'b1;
        exp_req.push_back('{q: 5'd3, f: 4'd0});
        exp_req.push_back('{q: 5'd3, f: 4'd1});
        exp_free.push_back(5'd3);
        sync_to_drive();
        apply_stimulus(5'd3, 4'd2);
        @(negedge clk);
        check_output("latency_t0", {31'd0, bus.o_rd_req}, 32'd0);
        @(negedge clk);
        check_output("latency_t1", {31'd0, bus.o_rd_req}, 32'd0);
        @(negedge clk);
        check_output("latency_t2", {31'd0, bus.o_rd_req}, 32'd1);
        wait_frees(1, 20);
        repeat (2) @(negedge clk);
        check_output("pending_after_a", bus.ov_pending_cnt, 0);
        check_output("hold_free_id", bus.ov_queue_id_free, 3);
        check_output("hold_rd_queue_id", bus.ov_rd_queue_id, 3);
        check_output("hold_rd_frag_id", bus.ov_rd_frag_id, 1);
        check_output("idle_no_req", {31'd0, bus.o_rd_req}, 32'd0);

        // Three back-to-back completions are drained strictly in order.
        exp_req.push_back('{q: 5'd5, f: 4'd0});
        exp_req.push_back('{q: 5'd9, f: 4'd0});
        exp_req.push_back('{q: 5'd9, f: 4'd1});
        exp_req.push_back('{q: 5'd9, f: 4'd2});
        exp_req.push_back('{q: 5'd1, f: 4'd0});
        exp_free.push_back(5'd5);
        exp_free.push_back(5'd9);
        exp_free.push_back(5'd1);
        sync_to_drive();
        apply_stimulus(5'd5, 4'd1);
        apply_stimulus(5'd9, 4'd3);
        apply_stimulus(5'd1, 4'd1);
        wait_frees(4, 60);
        check_output("req_queue_empty_b", exp_req.size(), 0);
        check_output("pending_after_b", bus.ov_pending_cnt, 0);

        // Queue 7 stalls without acks while 33 more completions arrive behind it.
        bus.i_rd_ack = 1'b0;
        exp_free.push_back(5'd7);
        sync_to_drive();
        apply_stimulus(5'd7, 4'd1);
        wait_req(10);
        check_output("stall_queue_id", bus.ov_rd_queue_id, 7);
        sync_to_drive();
        for (int i = 0; i < 33; i++) begin
            apply_stimulus(5'(i), 4'd1);
        end
        repeat (3) @(negedge clk);
        check_output("overflow_pulses", ovf_seen, 1);
        check_output("pending_full", bus.ov_pending_cnt, 32);
        sync_to_drive();
        apply_stimulus(5'd20, 4'd0);
        repeat (3) @(negedge clk);
        check_output("illegal_pulses", ill_seen, 1);
        check_output("pending_after_illegal", bus.ov_pending_cnt, 32);
        check_output("overflow_pulses_after_illegal", ovf_seen, 1);
        wait_frees(5, 400);
        check_output("timeout_pulses", timeout_seen, 1);
        check_output("free_queue_empty_d", exp_free.size(), 0);
        apply_reset();

        // Reset mid-drain of queue 4 with two completions pending behind it.
        sync_to_drive();
        apply_stimulus(5'd4, 4'd3);
        apply_stimulus(5'd10, 4'd1);
        apply_stimulus(5'd11, 4'd1);
        wait_req(10);
        check_output("drain_queue_id", bus.ov_rd_queue_id, 4);
        check_output("pending_before_reset", bus.ov_pending_cnt, 2);
        frees_base = frees_seen;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_drain_reset_outputs", out_vec(), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_cycles = 0;
        repeat (20) @(negedge clk);
        #1;
        check_output("no_req_after_reset", req_cycles, 0);
        check_output("no_free_after_reset", frees_seen, frees_base);
        check_output("pending_after_reset", bus.ov_pending_cnt, 0);

        // A fresh completion is still served after the reset.
        bus.i_rd_ack = 1'b1;
        exp_req.push_back('{q: 5'd12, f: 4'd0});
        exp_free.push_back(5'd12);
        sync_to_drive();
        apply_stimulus(5'd12, 4'd1);
        wait_frees(frees_base + 1, 20);
        check_output("req_queue_empty_end", exp_req.size(), 0);
        check_output("free_queue_empty_end", exp_free.size(), 0);

        $display("[TB] %0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule

// File: doc/queue_release_scheduler.md
QUEUE_RELEASE_SCHEDULER -- requirements
Module: queue_release_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  clock; i_rst_n  in  1  async reset, active low.
REQ-002 iv_queue_id  in  5  queue that holds every fragment of one packet.
REQ-003 iv_frag_num  in  4  fragment count of that packet; legal range 1..15.
REQ-004 i_queue_complete_wr  in  1  one-cycle strobe qualifying iv_queue_id and iv_frag_num.
REQ-005 ov_rd_queue_id  out  5  queue being drained.
REQ-006 ov_rd_frag_id  out  4  fragment index requested, 0-based.
REQ-007 o_rd_req  out  1  fragment read request, held until acknowledged.
REQ-008 i_rd_ack  in  1  fragment accepted by the downstream reader.
REQ-009 ov_queue_id_free  out  5  queue id returned to flow-table update.
REQ-010 o_queue_id_free_wr  out  1  one-cycle strobe qualifying ov_queue_id_free.
REQ-011 ov_pending_cnt  out  6  completed packets waiting, 0..32.
REQ-012 o_overflow_pulse  out  1  complete strobe dropped because the FIFO was full.
REQ-013 o_illegal_pulse  out  1  complete strobe dropped because iv_frag_num was 0.
REQ-014 o_timeout_pulse  out  1  drain aborted by the watchdog.

Function
REQ-015 Completion strobes SHALL enter a 32-deep first-in first-out completion FIFO; each entry holds the queue id and the fragment count (9 bits).
REQ-016 A strobe with iv_frag_num==0 SHALL NOT be written; o_illegal_pulse SHALL be 1 for exactly one cycle.
REQ-017 A strobe arriving while 32 entries are pending SHALL be dropped; o_overflow_pulse SHALL be 1 for exactly one cycle.
REQ-018 A FIFO write and a FIFO read in the same cycle SHALL both succeed; ov_pending_cnt is unchanged in that cycle.
REQ-019 The FSM SHALL have four states: IDLE, LOAD, REQ and FREE.
- IDLE: goes to LOAD when the FIFO is not empty, popping the head entry.
- LOAD: registers the queue id and fragment count and clears the fragment counter; goes to REQ.
- REQ: o_rd_req=1, ov_rd_frag_id=counter.
- FREE: o_queue_id_free_wr=1 for one cycle with ov_queue_id_free=the loaded id; goes to IDLE.
REQ-020 In REQ, when i_rd_ack=1 and the counter equals fragment count-1, the FSM SHALL go to FREE; otherwise, on i_rd_ack=1, the counter SHALL increment and o_rd_req SHALL stay high with no gap cycle.
REQ-021 i_rd_ack SHALL be ignored outside REQ.
REQ-022 o_rd_req SHALL first assert 2 cycles after i_queue_complete_wr (strobe at t, request at t+2) when the FSM is IDLE and the FIFO is empty.
REQ-023 A watchdog SHALL count 8-bit cycles in REQ without i_rd_ack and SHALL reset on every ack.
REQ-024 When the watchdog reaches 255, the FSM SHALL go to FREE, still freeing the queue, and o_timeout_pulse SHALL be 1 for one cycle.
REQ-025 Queues SHALL be served strictly in completion order; at most one queue SHALL be drained at a time.
REQ-026 ov_queue_id_free SHALL hold its last value outside FREE; ov_rd_queue_id and ov_rd_frag_id SHALL hold their values outside REQ.

Reset
REQ-027 While i_rst_n=0, all of the following SHALL be 0: every output, the FIFO pointers, ov_pending_cnt, the watchdog and the counter; the FSM SHALL be in IDLE.
REQ-028 Reset asserted mid-drain SHALL discard the drain and all pending entries without issuing any free strobe.

Structure
REQ-029 The shared package SHALL hold: queue-id width 5, fragment width 4, FIFO depth 32, watchdog limit 255 and the FSM state encodings.
REQ-030 The FIFO SHALL be one sub-module, completion_fifo (32x9, registered read, full/empty/usedw), instantiated once.

Verification
REQ-031 Complete strobe (q=3, n=2) into an empty, idle block, with ack asserted on each request -> o_rd_req at t+2 with frag 0 then frag 1; then free strobe with id 3 for one cycle; pending count returns to 0.
REQ-032 Strobes (q=5,n=1), (q=9,n=3), (q=1,n=1) back-to-back, ack held high -> frag sequence 5/0, 9/0, 9/1, 9/2, 1/0; frees in order 5, 9, 1.
REQ-033 33 strobes with ack held low -> pending count 32; the 33rd strobe gives one o_overflow_pulse; a strobe with n=0 gives o_illegal_pulse and pending count stays 32.
REQ-034 Drain q=7 with ack never asserted -> o_timeout_pulse after 255 request cycles, then a free of id 7 on the next cycle.
REQ-035 Reset asserted during REQ of q=4 with 2 entries pending -> all outputs 0 and no free strobe; after release, no request until a new strobe arrives.
